// File: rtl/sc_usb_pkg.sv
// rtl/sc_usb_pkg.sv - USB packet types, PID decode and CRC helpers shared by the receiver and generator
//
// Contents:
//   pid_e       : 4-bit USB PID codes
//   pktFormat   : packet class derived from a PID
//   rxStat_t    : packet status {rx_err, len_err, crc_err, pid_err}
//   pid_format  : PID -> packet class
//   crc5        : token CRC5 field over 11 bits, bit 0 = first bit on the wire
//   crc16_byte  : one-byte CRC16 update, data LSB first
package sc_usb_pkg;

    typedef enum logic [3:0] {
        PID_RSVD  = 4'h0,
        PID_OUT   = 4'h1,
        PID_ACK   = 4'h2,
        PID_DATA0 = 4'h3,
        PID_PING  = 4'h4,
        PID_SOF   = 4'h5,
        PID_NYET  = 4'h6,
        PID_DATA2 = 4'h7,
        PID_SPLIT = 4'h8,
        PID_IN    = 4'h9,
        PID_NAK   = 4'hA,
        PID_DATA1 = 4'hB,
        PID_PRE   = 4'hC,
        PID_SETUP = 4'hD,
        PID_STALL = 4'hE,
        PID_MDATA = 4'hF
    } pid_e;

    typedef enum logic [1:0] {
        FMT_HSK   = 2'd0,
        FMT_TOKEN = 2'd1,
        FMT_DATA  = 2'd2,
        FMT_BAD   = 2'd3
    } pktFormat;

    typedef struct packed {
        logic rx_err;
        logic len_err;
        logic crc_err;
        logic pid_err;
    } rxStat_t;

    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [10:0] MAX_PAYLOAD    = 11'd1024;

    // Reserved, PRE and SPLIT are not accepted by this receiver and map to FMT_BAD.
    function automatic pktFormat pid_format(input logic [3:0] pid);
        pktFormat f;
        case (pid)
            PID_OUT, PID_IN, PID_SETUP, PID_PING, PID_SOF:  f = FMT_TOKEN;
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:     f = FMT_DATA;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:          f = FMT_HSK;
            default:                                        f = FMT_BAD;
        endcase
        return f;
    endfunction

    // x^5+x^2+1, preset all ones. The register is inverted and sent MSB first,
    // so the returned field is bit-reversed to match the byte it arrives in.
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        logic [4:0] r;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        for (int i = 0; i < 5; i++) begin
            r[i] = ~c[4-i];
        end
        return r;
    endfunction

    // x^16+x^15+x^2+1, shift-left register, data fed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/sc_ulpi_upr_if.sv
// rtl/sc_ulpi_upr_if.sv - byte stream from the ULPI engine and decoded packet fields
//
// RXD_*    : received bytes (VALID strobe, DATA, LAST marks final byte, ERR = RxError)
// PKT_RX_* : decoded packet: COMP pulse, STAT, PID, ADR, EPN, FMN, payload DAT/DAT_VALID, NUM
// slave    : the packet receiver; master : the byte source / packet consumer
interface sc_ulpi_upr_if;

    logic        RXD_VALID;
    logic [7:0]  RXD_DATA;
    logic        RXD_LAST;
    logic        RXD_ERR;

    logic        PKT_RX_COMP;
    logic [3:0]  PKT_RX_STAT;
    logic [3:0]  PKT_RX_PID;
    logic [6:0]  PKT_RX_ADR;
    logic [3:0]  PKT_RX_EPN;
    logic [10:0] PKT_RX_FMN;
    logic [7:0]  PKT_RX_DAT;
    logic        PKT_RX_DAT_VALID;
    logic [10:0] PKT_RX_NUM;

    modport slave (
        input  RXD_VALID, RXD_DATA, RXD_LAST, RXD_ERR,
        output PKT_RX_COMP, PKT_RX_STAT, PKT_RX_PID, PKT_RX_ADR, PKT_RX_EPN,
        output PKT_RX_FMN, PKT_RX_DAT, PKT_RX_DAT_VALID, PKT_RX_NUM
    );

    modport master (
        output RXD_VALID, RXD_DATA, RXD_LAST, RXD_ERR,
        input  PKT_RX_COMP, PKT_RX_STAT, PKT_RX_PID, PKT_RX_ADR, PKT_RX_EPN,
        input  PKT_RX_FMN, PKT_RX_DAT, PKT_RX_DAT_VALID, PKT_RX_NUM
    );

endinterface

// File: rtl/sc_ulpi_upr_dpath.sv
// rtl/sc_ulpi_upr_dpath.sv - data packet path: 2-byte holding pipe, CRC16 and payload counter
//
// ULPICLK/ULPIRSTB : clock, async active-low reset
// clr              : new PID accepted; empties pipe, presets CRC, zeroes count
// in_valid/in_data : data-phase byte
// dat/dat_valid    : forwarded payload byte (CRC bytes never leave the pipe)
// num              : forwarded payload bytes
// empty            : pipe holds no byte yet (packet too short for a CRC)
// ovf              : incoming byte would push payload beyond the maximum
// res_ok           : CRC residual including in_data is the good-packet constant
module sc_ulpi_upr_dpath
    import sc_usb_pkg::*;
(
    input  logic        ULPICLK,
    input  logic        ULPIRSTB,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [7:0]  dat,
    output logic        dat_valid,
    output logic [10:0] num,
    output logic        empty,
    output logic        ovf,
    output logic        res_ok
);

    logic [15:0] crc;
    logic [15:0] crc_nxt;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [1:0]  fill;
    logic        full;

    assign crc_nxt = crc16_byte(crc, in_data);
    assign res_ok  = (crc_nxt == CRC16_RESIDUAL);
    assign full    = (fill == 2'd2);
    assign empty   = (fill == 2'd0);
    assign ovf     = in_valid && full && (num == MAX_PAYLOAD);

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            crc       <= CRC16_INIT;
            h0        <= 8'h00;
            h1        <= 8'h00;
            fill      <= 2'd0;
            num       <= 11'd0;
            dat       <= 8'h00;
            dat_valid <= 1'b0;
        end else begin
            dat_valid <= 1'b0;
            if (clr) begin
                crc  <= CRC16_INIT;
                fill <= 2'd0;
                num  <= 11'd0;
            end else if (in_valid) begin
                crc <= crc_nxt;
                case (fill)
                    2'd0: begin
                        h0   <= in_data;
                        fill <= 2'd1;
                    end
                    2'd1: begin
                        h1   <= in_data;
                        fill <= 2'd2;
                    end
                    default: begin
                        h0 <= h1;
                        h1 <= in_data;
                    end
                endcase
                // The oldest byte is payload once two newer bytes follow it.
                if (full && (num != MAX_PAYLOAD)) begin
                    dat       <= h0;
                    dat_valid <= 1'b1;
                    num       <= num + 11'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sc_ulpi_upr.sv
// rtl/sc_ulpi_upr.sv - ULPI receive packet decoder: PID check, token fields, data payload, status
//
// ULPICLK  : 60 MHz ULPI clock, rising edge
// ULPIRSTB : asynchronous active-low reset
// bus      : sc_ulpi_upr_if.slave - RXD_* byte stream in, PKT_RX_* decoded packet out
module sc_ulpi_upr
    import sc_usb_pkg::*;
(
    input  logic           ULPICLK,
    input  logic           ULPIRSTB,
    sc_ulpi_upr_if.slave   bus
);

    localparam logic [2:0] RX_IDLE = 3'd0;
    localparam logic [2:0] RX_TOK1 = 3'd1;
    localparam logic [2:0] RX_TOK2 = 3'd2;
    localparam logic [2:0] RX_DATA = 3'd3;
    localparam logic [2:0] RX_DROP = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    rxStat_t    stat_acc;
    rxStat_t    flags;
    rxStat_t    stat_now;
    logic [7:0] tok_b1;
    pktFormat   fmt;
    logic       pid_bad;
    logic       is_sof;
    logic       byte_last;
    logic       pid_acc;
    logic       dp_in;
    logic       d_empty;
    logic       d_ovf;
    logic       d_res_ok;

    assign fmt       = pid_format(bus.RXD_DATA[3:0]);
    assign pid_bad   = (bus.RXD_DATA[7:4] != ~bus.RXD_DATA[3:0]) || (fmt == FMT_BAD);
    assign is_sof    = (bus.PKT_RX_PID == PID_SOF);
    assign byte_last = bus.RXD_VALID && bus.RXD_LAST;
    assign pid_acc   = (state == RX_IDLE) && bus.RXD_VALID;
    assign dp_in     = (state == RX_DATA) && bus.RXD_VALID;

    always_comb begin
        state_nxt      = state;
        flags          = '0;
        // RxError counts on any cycle of a packet, including the PID cycle itself.
        flags.rx_err   = bus.RXD_ERR && ((state != RX_IDLE) || bus.RXD_VALID);
        case (state)
            RX_IDLE: begin
                if (bus.RXD_VALID) begin
                    if (pid_bad) begin
                        flags.pid_err = 1'b1;
                        state_nxt     = RX_DROP;
                    end else begin
                        case (fmt)
                            FMT_TOKEN: begin
                                flags.len_err = bus.RXD_LAST;
                                state_nxt     = RX_TOK1;
                            end
                            FMT_DATA: begin
                                flags.len_err = bus.RXD_LAST;
                                state_nxt     = RX_DATA;
                            end
                            default: begin
                                flags.len_err = !bus.RXD_LAST;
                                state_nxt     = RX_DROP;
                            end
                        endcase
                    end
                end
            end
            RX_TOK1: begin
                if (bus.RXD_VALID) begin
                    flags.len_err = bus.RXD_LAST;
                    state_nxt     = RX_TOK2;
                end
            end
            RX_TOK2: begin
                if (bus.RXD_VALID) begin
                    flags.crc_err = (bus.RXD_DATA[7:3] != crc5({bus.RXD_DATA[2:0], tok_b1}));
                    flags.len_err = !bus.RXD_LAST;
                    state_nxt     = RX_DROP;
                end
            end
            RX_DATA: begin
                if (bus.RXD_VALID) begin
                    if (d_ovf) begin
                        flags.len_err = 1'b1;
                        state_nxt     = RX_DROP;
                    end else if (bus.RXD_LAST) begin
                        // A single byte after the PID cannot hold a CRC; only length is reported.
                        flags.len_err = d_empty;
                        flags.crc_err = !d_empty && !d_res_ok;
                    end
                end
            end
            RX_DROP: begin
                state_nxt = RX_DROP;
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
        if (byte_last) begin
            state_nxt = RX_IDLE;
        end
        stat_now = rxStat_t'(stat_acc | flags);
    end

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            state           <= RX_IDLE;
            stat_acc        <= '0;
            tok_b1          <= 8'h00;
            bus.PKT_RX_COMP <= 1'b0;
            bus.PKT_RX_STAT <= 4'h0;
            bus.PKT_RX_PID  <= 4'h0;
            bus.PKT_RX_ADR  <= 7'h00;
            bus.PKT_RX_EPN  <= 4'h0;
            bus.PKT_RX_FMN  <= 11'h000;
        end else begin
            state           <= state_nxt;
            bus.PKT_RX_COMP <= byte_last;
            if (byte_last) begin
                bus.PKT_RX_STAT <= stat_now;
                stat_acc        <= '0;
            end else begin
                stat_acc        <= stat_now;
            end
            if (pid_acc) begin
                bus.PKT_RX_PID <= bus.RXD_DATA[3:0];
                bus.PKT_RX_ADR <= 7'h00;
                bus.PKT_RX_EPN <= 4'h0;
                bus.PKT_RX_FMN <= 11'h000;
            end
            if ((state == RX_TOK1) && bus.RXD_VALID) begin
                tok_b1 <= bus.RXD_DATA;
                if (is_sof) begin
                    bus.PKT_RX_FMN[7:0] <= bus.RXD_DATA;
                end else begin
                    bus.PKT_RX_ADR    <= bus.RXD_DATA[6:0];
                    bus.PKT_RX_EPN[0] <= bus.RXD_DATA[7];
                end
            end
            if ((state == RX_TOK2) && bus.RXD_VALID) begin
                if (is_sof) begin
                    bus.PKT_RX_FMN[10:8] <= bus.RXD_DATA[2:0];
                end else begin
                    bus.PKT_RX_EPN[3:1]  <= bus.RXD_DATA[2:0];
                end
            end
        end
    end

    sc_ulpi_upr_dpath u_dpath (
        .ULPICLK   (ULPICLK),
        .ULPIRSTB  (ULPIRSTB),
        .clr       (pid_acc),
        .in_valid  (dp_in),
        .in_data   (bus.RXD_DATA),
        .dat       (bus.PKT_RX_DAT),
        .dat_valid (bus.PKT_RX_DAT_VALID),
        .num       (bus.PKT_RX_NUM),
        .empty     (d_empty),
        .ovf       (d_ovf),
        .res_ok    (d_res_ok)
    );

endmodule

// File: doc/sc_ulpi_upr.md
SC_ULPI_UPR -- requirements
Module: sc_ulpi_upr

Interface
REQ-001 The block SHALL have one clock, ULPICLK, and one reset, ULPIRSTB; ULPIRSTB SHALL be asynchronous and active-low.
REQ-002 ULPICLK  in  1  ULPI 60 MHz clock; all logic rising-edge.
REQ-003 ULPIRSTB  in  1  asynchronous active-low reset.
REQ-004 RXD_VALID  in  1  received byte strobe from the ULPI protocol engine, one byte per asserted cycle.
REQ-005 RXD_DATA  in  8  received byte, LSB = first bit on the bus.
REQ-006 RXD_LAST  in  1  qualified by RXD_VALID; marks the final byte of a packet.
REQ-007 RXD_ERR  in  1  RxError seen during the current packet; sampled on any cycle.
REQ-008 PKT_RX_COMP  out  1  one-cycle pulse: packet ended, all PKT_RX_* fields valid.
REQ-009 PKT_RX_STAT  out  4  {rxErr, lenErr, crcErr, pidErr}, valid with PKT_RX_COMP.
REQ-010 PKT_RX_PID  out  4  received PID[3:0].
REQ-011 PKT_RX_ADR / PKT_RX_EPN  out  7 / 4  token address / endpoint.
REQ-012 PKT_RX_FMN  out  11  SOF frame number.
REQ-013 PKT_RX_DAT / PKT_RX_DAT_VALID  out  8 / 1  data payload byte stream, CRC bytes excluded.
REQ-014 PKT_RX_NUM  out  11  payload byte count of the last data packet (0..1024).

Function
REQ-015 States SHALL be rxIdle, rxTok1, rxTok2, rxData, rxDrop.
REQ-016 rxIdle: first valid byte = PID; pidErr if byte[7:4] != ~byte[3:0], or PID is reserved, PRE or SPLIT.
REQ-017 The PID byte SHALL then route to: token (OUT/IN/SETUP/PING/SOF) -> rxTok1; DATA0/1/2/MDATA -> rxData; handshake -> rxIdle.
REQ-018 Token byte1 SHALL load ADR = byte[6:0], EPN[0] = byte[7] (SOF: FMN[7:0]).
REQ-019 Token byte2 SHALL load EPN[3:1] = byte[2:0] (SOF: FMN[10:8]); crcErr if byte[7:3] != package CRC5 over {EPN,ADR} (SOF: FMN), bit order identical to the generator.
REQ-020 Length rule: handshake exactly 1 byte, token exactly 3, data 3..1027; RXD_LAST early or late -> lenErr.
REQ-021 On lenErr before RXD_LAST, the block SHALL go to rxDrop and discard bytes up to RXD_LAST.
REQ-022 rxData: CRC16 (x^16+x^15+x^2+1, init 16'hFFFF, LSB-first) over payload plus CRC bytes; crcErr unless residual == 16'h800D at RXD_LAST.
REQ-023 rxData: a 2-byte holding pipe SHALL forward a byte on PKT_RX_DAT_VALID only once two newer bytes exist; the two bytes held at RXD_LAST (the CRC) SHALL never be forwarded.
REQ-024 Payload beyond 1024 bytes SHALL raise lenErr, stop forwarding, and enter rxDrop.
REQ-025 PKT_RX_COMP SHALL pulse exactly once per packet, the cycle after the RXD_VALID&RXD_LAST byte, for good and errored packets alike; state returns to rxIdle.
REQ-026 RXD_ERR anywhere in a packet SHALL set rxErr, reported at its PKT_RX_COMP; other flags are still evaluated.
REQ-027 Errored packets SHALL still pulse PKT_RX_COMP; the consumer discards already-forwarded payload.
REQ-028 PKT_RX_PID/ADR/EPN/FMN/NUM SHALL hold their value until the next PID byte is accepted.
REQ-029 PKT_RX_NUM SHALL equal forwarded payload bytes, saturating at 1024.
REQ-030 RXD_LAST on the PID byte of a token or data PID SHALL give lenErr with COMP next cycle.

Reset
REQ-031 On ULPIRSTB low: state rxIdle; PKT_RX_COMP, PKT_RX_DAT_VALID, PKT_RX_STAT, and all field outputs SHALL be 0; CRC registers SHALL be 16'hFFFF.
REQ-032 Reset mid-packet SHALL abort with no PKT_RX_COMP; the first byte after release SHALL be treated as a PID.

Structure
REQ-033 sc_usb_pkg SHALL hold the PID enum, the pktFormat type, the CRC5 function, a CRC16 per-byte function, and the rxStat_t packed struct.
REQ-034 The CRC5 function SHALL move into sc_usb_pkg and be shared with the packet generator.
REQ-035 The data path (holding pipe, CRC16, byte counter) SHALL be one sub-module, sc_ulpi_upr_dpath.

Verification
REQ-036 Bytes 2D 00 10 with LAST on 10 -> COMP, PID=D, ADR=0, EPN=0, STAT=0.
REQ-037 Bytes C3 80 06 00 01 00 00 40 00 DD 94 -> 8 DAT_VALID pulses 80..00, NUM=8, STAT=0; repeat with last byte 95 -> crcErr.
REQ-038 Byte D2 with LAST -> COMP, PID=2, STAT=0; byte D3 with LAST -> pidErr.
REQ-039 2D 00 with LAST on 00 -> lenErr; C3 followed by 1030 bytes -> exactly 1024 DAT_VALID pulses, lenErr, NUM=1024.
REQ-040 RXD_ERR pulse mid data packet -> rxErr set at COMP; reset asserted mid packet -> no COMP, all outputs 0, next D2 decoded correctly.
